ecc_scrub_ctrl: RTL and testbench

Background scrubber for a bank of `ecc_reg` instances. It walks the bank one register per cycle and samples each register's error flags. Single-bit and parity-bit errors are repaired by writing the corrected `reg_dout` back through the register's write port. Every error is reported on a valid/ready event interface, and the block keeps saturating error counters. It sits beside the `generate` array of `ecc_reg` and drives the scrub-side write enables and data, which are muxed with host writes outside this block.

---
 rtl/ecc_scrub_ctrl_pkg.sv | 23 ++
 rtl/ecc_scrub_ctrl_if.sv | 34 +++
 rtl/ecc_scrub_ctrl_sat_counter.sv | 27 ++
 rtl/ecc_scrub_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ecc_scrub_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_scrub_ctrl_pkg.sv
// ecc_scrub_pkg
// Shared types for the ECC background scrubber:
//   scrub_state_t : FSM state encoding (also exported on the debug port)
//   err_type_t    : event type reported on the error-event interface
package ecc_scrub_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_CHECK     = 2'd1,
        S_WRITEBACK = 2'd2,
        S_REPORT    = 2'd3
    } scrub_state_t;

    // ERR_NONE is only the reset value of the event type register;
    // it is never presented with err_valid = 1.
    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_SINGLE = 2'b01,
        ERR_DOUBLE = 2'b10,
        ERR_PARITY = 2'b11
    } err_type_t;

endpackage

// File: rtl/ecc_scrub_ctrl_if.sv
// ecc_scrub_ctrl_if
// Error-event channel from the scrubber to its consumer.
//   err_valid : event present (driven by master)
//   err_ready : consumer accepts the event (driven by slave)
//   err_idx   : register index of the event
//   err_type  : event type (single / double / parity)
// Handshake: an event transfers on a clock edge where err_valid and
// err_ready are both 1. Once err_valid rises, err_idx and err_type stay
// stable and err_valid stays high until that transfer; err_ready may be
// driven freely and does not depend on err_valid.
interface ecc_scrub_ctrl_if
    import ecc_scrub_pkg::*;
#(
    parameter int IDX_W = 7
);
    logic             err_valid;
    logic             err_ready;
    logic [IDX_W-1:0] err_idx;
    err_type_t        err_type;

    modport master (
        output err_valid,
        output err_idx,
        output err_type,
        input  err_ready
    );

    modport slave (
        input  err_valid,
        input  err_idx,
        input  err_type,
        output err_ready
    );
endinterface

// File: rtl/ecc_scrub_ctrl_sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk, reset_b : clock, asynchronous active-low reset
//   inc          : count up by one (ignored once at all-ones)
//   clr          : synchronous clear, wins over inc
//   count        : current value
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl
// Background scrubber for a bank of ecc_reg instances. Visits one register
// per cycle, repairs single-bit and parity errors by writing the corrected
// data back, reports every error on the event channel and keeps saturating
// counters of corrected (single) and uncorrectable (double) errors.
// Ports:
//   clk, reset_b      : clock, asynchronous active-low reset
//   scrub_en          : level enable for scanning
//   host_wr           : host write this cycle, stalls scrub write-back
//   reg_dout          : corrected data of every register
//   single/double/parity_bit_err : per-register error flags
//   w_en, w_din       : one-hot scrub write enable and shared write data
//   err               : error-event channel (master side)
//   sbe_count, dbe_count, clr_counts : error counters and their clear
//   dbg_state, dbg_idx: current FSM state and scan index
module ecc_scrub_ctrl
    import ecc_scrub_pkg::*;
#(
    parameter int NUM_REGS     = 100,
    parameter int NUM_REG_BITS = 8,
    parameter int CNT_WIDTH    = 16,
    localparam int IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_b,
    input  logic                    scrub_en,
    input  logic                    host_wr,
    input  logic [NUM_REG_BITS-1:0] reg_dout [NUM_REGS],
    input  logic [NUM_REGS-1:0]     single_bit_err,
    input  logic [NUM_REGS-1:0]     double_bit_err,
    input  logic [NUM_REGS-1:0]     parity_bit_err,
    output logic [NUM_REGS-1:0]     w_en,
    output logic [NUM_REG_BITS-1:0] w_din,
    ecc_scrub_ctrl_if.master        err,
    output logic [CNT_WIDTH-1:0]    sbe_count,
    output logic [CNT_WIDTH-1:0]    dbe_count,
    input  logic                    clr_counts,
    output scrub_state_t            dbg_state,
    output logic [IDX_W-1:0]        dbg_idx
);

    scrub_state_t            state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_REG_BITS-1:0] w_din_q, w_din_d;
    logic                    err_valid_q, err_valid_d;
    logic [IDX_W-1:0]        err_idx_q, err_idx_d;
    err_type_t               err_type_q, err_type_d;
    logic                    handshake;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(NUM_REGS - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    assign handshake = err_valid_q && err.err_ready;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            w_din_q     <= '0;
            err_valid_q <= 1'b0;
            err_idx_q   <= '0;
            err_type_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            w_din_q     <= w_din_d;
            err_valid_q <= err_valid_d;
            err_idx_q   <= err_idx_d;
            err_type_q  <= err_type_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        w_din_d     = w_din_q;
        err_valid_d = err_valid_q;
        err_idx_d   = err_idx_q;
        err_type_d  = err_type_q;
        case (state_q)
            S_IDLE: begin
                if (scrub_en) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Double wins over single, single over parity.
                if (double_bit_err[idx_q]) begin
                    err_idx_d   = idx_q;
                    err_type_d  = ERR_DOUBLE;
                    err_valid_d = 1'b1;
                    state_d     = S_REPORT;
                end else if (single_bit_err[idx_q]) begin
                    w_din_d    = reg_dout[idx_q];
                    err_idx_d  = idx_q;
                    err_type_d = ERR_SINGLE;
                    state_d    = S_WRITEBACK;
                end else if (parity_bit_err[idx_q]) begin
                    w_din_d    = reg_dout[idx_q];
                    err_idx_d  = idx_q;
                    err_type_d = ERR_PARITY;
                    state_d    = S_WRITEBACK;
                end else begin
                    idx_d = next_idx(idx_q);
                    if (!scrub_en) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WRITEBACK: begin
                // The write lands in the first cycle the host leaves free.
                if (!host_wr) begin
                    err_valid_d = 1'b1;
                    state_d     = S_REPORT;
                end
            end
            S_REPORT: begin
                if (err.err_ready) begin
                    err_valid_d = 1'b0;
                    idx_d       = next_idx(idx_q);
                    state_d     = scrub_en ? S_CHECK : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered state gated by host_wr so the host always wins the port.
    always_comb begin
        w_en = '0;
        if ((state_q == S_WRITEBACK) && !host_wr) begin
            w_en[idx_q] = 1'b1;
        end
    end

    assign w_din         = w_din_q;
    assign err.err_valid = err_valid_q;
    assign err.err_idx   = err_idx_q;
    assign err.err_type  = err_type_q;
    assign dbg_state     = state_q;
    assign dbg_idx       = idx_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_sbe_cnt (
        .clk     (clk),
        .reset_b (reset_b),
        .inc     (handshake && (err_type_q == ERR_SINGLE)),
        .clr     (clr_counts),
        .count   (sbe_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_dbe_cnt (
        .clk     (clk),
        .reset_b (reset_b),
        .inc     (handshake && (err_type_q == ERR_DOUBLE)),
        .clr     (clr_counts),
        .count   (dbe_count)
    );

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb_ecc_scrub_ctrl
// Directed bench for ecc_scrub_ctrl with a 100-register bank and narrow
// 4-bit counters so saturation is reachable in a short run.
module tb_ecc_scrub_ctrl;
    import ecc_scrub_pkg::*;

    localparam int NR  = 100;
    localparam int NB  = 8;
    localparam int CW  = 4;
    localparam int IW  = 7;

    logic              clk;
    logic              reset_b;
    logic              scrub_en;
    logic              host_wr;
    logic [NB-1:0]     reg_dout [NR];
    logic [NR-1:0]     single_bit_err;
    logic [NR-1:0]     double_bit_err;
    logic [NR-1:0]     parity_bit_err;
    logic [NR-1:0]     w_en;
    logic [NB-1:0]     w_din;
    logic [CW-1:0]     sbe_count;
    logic [CW-1:0]     dbe_count;
    logic              clr_counts;
    scrub_state_t      dbg_state;
    logic [IW-1:0]     dbg_idx;

    int total;
    int bad;

    ecc_scrub_ctrl_if #(.IDX_W(IW)) err_if ();

    ecc_scrub_ctrl #(
        .NUM_REGS     (NR),
        .NUM_REG_BITS (NB),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk            (clk),
        .reset_b        (reset_b),
        .scrub_en       (scrub_en),
        .host_wr        (host_wr),
        .reg_dout       (reg_dout),
        .single_bit_err (single_bit_err),
        .double_bit_err (double_bit_err),
        .parity_bit_err (parity_bit_err),
        .w_en           (w_en),
        .w_din          (w_din),
        .err            (err_if),
        .sbe_count      (sbe_count),
        .dbe_count      (dbe_count),
        .clr_counts     (clr_counts),
        .dbg_state      (dbg_state),
        .dbg_idx        (dbg_idx)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " w_en"},      w_en, '0);
        chk({tag, " w_din"},     w_din, '0);
        chk({tag, " err_valid"}, err_if.err_valid, 0);
        chk({tag, " err_idx"},   err_if.err_idx, 0);
        chk({tag, " err_type"},  err_if.err_type, 0);
        chk({tag, " sbe"},       sbe_count, 0);
        chk({tag, " dbe"},       dbe_count, 0);
        chk({tag, " state"},     dbg_state, S_IDLE);
        chk({tag, " idx"},       dbg_idx, 0);
    endtask

    initial begin
        int exp_idx;
        int exp_sbe;
        total = 0;
        bad   = 0;

        reset_b          = 1'b0;
        scrub_en         = 1'b0;
        host_wr          = 1'b0;
        clr_counts       = 1'b0;
        err_if.err_ready = 1'b0;
        single_bit_err   = '0;
        double_bit_err   = '0;
        parity_bit_err   = '0;
        for (int i = 0; i < NR; i++) reg_dout[i] = NB'(i + 16);

        // Reset state
        repeat (3) tick();
        chk_reset_values("reset");
        reset_b = 1'b1;
        tick();
        chk("idle_hold state", dbg_state, S_IDLE);

        // Clean pass: idx walks 0..99 and wraps
        scrub_en = 1'b1;
        tick();
        chk("clean start state", dbg_state, S_CHECK);
        chk("clean start idx", dbg_idx, 0);
        for (int i = 1; i < NR; i++) begin
            tick();
            chk("clean idx", dbg_idx, i);
            chk("clean w_en", w_en, '0);
            chk("clean err_valid", err_if.err_valid, 0);
        end
        tick();
        chk("clean wrap idx", dbg_idx, 0);

        // Single-bit error at 42
        single_bit_err[42] = 1'b1;
        reg_dout[42]       = 8'hA5;
        err_if.err_ready   = 1'b1;
        repeat (42) tick();
        chk("sbe reach idx", dbg_idx, 42);
        tick();
        chk("sbe wb w_en", w_en, oh(42));
        chk("sbe wb w_din", w_din, 8'hA5);
        chk("sbe wb valid", err_if.err_valid, 0);
        tick();
        chk("sbe rpt w_en", w_en, '0);
        chk("sbe rpt valid", err_if.err_valid, 1);
        chk("sbe rpt idx", err_if.err_idx, 42);
        chk("sbe rpt type", err_if.err_type, ERR_SINGLE);
        tick();
        chk("sbe count", sbe_count, 1);
        chk("sbe dbe count", dbe_count, 0);
        chk("sbe next idx", dbg_idx, 43);
        chk("sbe next valid", err_if.err_valid, 0);
        single_bit_err[42] = 1'b0;

        // Double + single at 7: double wins, no write-back
        double_bit_err[7] = 1'b1;
        single_bit_err[7] = 1'b1;
        repeat (64) tick();
        chk("dbe reach idx", dbg_idx, 7);
        tick();
        chk("dbe state", dbg_state, S_REPORT);
        chk("dbe w_en", w_en, '0);
        chk("dbe valid", err_if.err_valid, 1);
        chk("dbe idx", err_if.err_idx, 7);
        chk("dbe type", err_if.err_type, ERR_DOUBLE);
        tick();
        chk("dbe count", dbe_count, 1);
        chk("dbe sbe count", sbe_count, 1);
        chk("dbe next idx", dbg_idx, 8);
        double_bit_err[7] = 1'b0;
        single_bit_err[7] = 1'b0;

        // Parity at 3 with host stalling the write-back for 4 cycles
        parity_bit_err[3] = 1'b1;
        reg_dout[3]       = 8'h3C;
        host_wr           = 1'b1;
        repeat (95) tick();
        chk("par reach idx", dbg_idx, 3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("par stall state", dbg_state, S_WRITEBACK);
            chk("par stall w_en", w_en, '0);
        end
        host_wr          = 1'b0;
        err_if.err_ready = 1'b0;
        #1;
        chk("par w_en", w_en, oh(3));
        chk("par w_din", w_din, 8'h3C);
        tick();
        chk("par w_en pulse", w_en, '0);

        // Consumer back-pressure; scrub_en dropped mid-report
        for (int i = 0; i < 10; i++) begin
            chk("bp valid", err_if.err_valid, 1);
            chk("bp idx", err_if.err_idx, 3);
            chk("bp type", err_if.err_type, ERR_PARITY);
            chk("bp scan idx", dbg_idx, 3);
            if (i == 4) scrub_en = 1'b0;
            tick();
        end
        err_if.err_ready = 1'b1;
        tick();
        chk("bp after state", dbg_state, S_IDLE);
        chk("bp after valid", err_if.err_valid, 0);
        chk("bp after idx", dbg_idx, 4);
        chk("par sbe unchanged", sbe_count, 1);
        chk("par dbe unchanged", dbe_count, 1);
        parity_bit_err[3] = 1'b0;
        tick();
        chk("idle resume idx", dbg_idx, 4);
        chk("idle stays", dbg_state, S_IDLE);

        // Saturation: every register reports a single-bit error
        single_bit_err = '1;
        scrub_en       = 1'b1;
        tick();
        exp_idx = 4;
        exp_sbe = 1;
        for (int n = 0; n < 17; n++) begin
            repeat (3) tick();
            exp_idx++;
            exp_sbe = (exp_sbe < 15) ? exp_sbe + 1 : 15;
            chk("sat sbe", sbe_count, exp_sbe);
            chk("sat idx", dbg_idx, exp_idx);
        end
        chk("sat final", sbe_count, 4'hF);

        // Clear while saturated and incrementing
        repeat (2) tick();
        clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
        exp_idx++;
        chk("clr sat sbe", sbe_count, 0);
        chk("clr dbe", dbe_count, 0);
        repeat (3) tick();
        exp_idx++;
        chk("post clr sbe", sbe_count, 1);
        repeat (2) tick();
        clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
        exp_idx++;
        chk("clr vs inc sbe", sbe_count, 0);
        chk("clr vs inc idx", dbg_idx, exp_idx);

        // Reset during write-back
        tick();
        chk("rst wb state", dbg_state, S_WRITEBACK);
        chk("rst wb w_en", w_en, oh(exp_idx));
        chk("rst wb w_din", w_din, NB'(exp_idx + 16));
        reset_b = 1'b0;
        #1;
        chk_reset_values("mid reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
